// File: rtl/uio_bus_arbiter_if.sv
// Bus bundle between the two uio requesters and the pad arbiter.
// The slave modport is the arbiter side.
interface uio_bus_arbiter_if;
  logic [1:0] req;
  logic [1:0] dir;
  logic [7:0] wdata0;
  logic [7:0] wdata1;
  logic [7:0] uio_in;
  logic [1:0] gnt;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic [7:0] rdata;
  logic       rvalid;
  logic       busy;

  modport master (
    output req, dir, wdata0, wdata1, uio_in,
    input  gnt, uio_out, uio_oe, rdata, rvalid, busy
  );

  modport slave (
    input  req, dir, wdata0, wdata1, uio_in,
    output gnt, uio_out, uio_oe, rdata, rvalid, busy
  );
endinterface

// File: rtl/uio_bus_arbiter.sv
// Round-robin arbiter sharing the uio pad bank between two requesters, with a
// hold limit and a tristated turnaround gap between owners.
module uio_bus_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned TURN_CYC = 1
) (
    input logic                clk,
    input logic                rst,
    input logic                ena,
    uio_bus_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

    state_t     state, state_n;
    logic [1:0] gnt, gnt_n;
    logic       owner, owner_n;
    logic       owner_dir, owner_dir_n;
    logic       last, last_n;
    logic [7:0] hold_cnt, hold_cnt_n;
    logic [3:0] turn_cnt, turn_cnt_n;
    logic [7:0] rdata, rdata_n;
    logic       rvalid, rvalid_n;

    logic       winner;
    logic       can_arb;
    logic       do_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            owner     <= 1'b0;
            owner_dir <= 1'b0;
            last      <= 1'b1;
            hold_cnt  <= '0;
            turn_cnt  <= '0;
            rdata     <= '0;
            rvalid    <= 1'b0;
        end else begin
            state     <= state_n;
            gnt       <= gnt_n;
            owner     <= owner_n;
            owner_dir <= owner_dir_n;
            last      <= last_n;
            hold_cnt  <= hold_cnt_n;
            turn_cnt  <= turn_cnt_n;
            rdata     <= rdata_n;
            rvalid    <= rvalid_n;
        end
    end

    // On contention the requester that did not win last time takes the bank.
    always_comb begin
        winner  = (bus.req == 2'b11) ? ~last : bus.req[1];
        can_arb = ena && (bus.req != 2'b00);
    end

    always_comb begin
        state_n     = state;
        gnt_n       = gnt;
        owner_n     = owner;
        owner_dir_n = owner_dir;
        last_n      = last;
        hold_cnt_n  = hold_cnt;
        turn_cnt_n  = turn_cnt;
        rdata_n     = rdata;
        rvalid_n    = rvalid;
        do_grant    = 1'b0;

        case (state)
            IDLE: begin
                rvalid_n = 1'b0;
                if (can_arb) do_grant = 1'b1;
            end
            GRANT: begin
                if (!owner_dir) begin
                    rdata_n  = bus.uio_in;
                    rvalid_n = 1'b1;
                end
                if (hold_cnt != 8'(MAX_HOLD)) hold_cnt_n = hold_cnt + 8'd1;
                if (!ena || !bus.req[owner] ||
                    ((hold_cnt == 8'(MAX_HOLD)) && bus.req[~owner])) begin
                    gnt_n      = '0;
                    rvalid_n   = 1'b0;
                    turn_cnt_n = 4'd1;
                    state_n    = TURN;
                end
            end
            TURN: begin
                rvalid_n = 1'b0;
                if (turn_cnt == 4'(TURN_CYC)) begin
                    if (can_arb) do_grant = 1'b1;
                    else         state_n  = IDLE;
                end else begin
                    turn_cnt_n = turn_cnt + 4'd1;
                end
            end
            default: begin
                gnt_n    = '0;
                rvalid_n = 1'b0;
                state_n  = IDLE;
            end
        endcase

        if (do_grant) begin
            gnt_n       = winner ? 2'b10 : 2'b01;
            owner_n     = winner;
            owner_dir_n = bus.dir[winner];
            last_n      = winner;
            hold_cnt_n  = 8'd1;
            state_n     = GRANT;
        end
    end

    // Pad drive is decoded from registered state so write data passes straight through.
    always_comb begin
        bus.uio_oe  = '0;
        bus.uio_out = '0;
        if (state == GRANT && owner_dir) begin
            bus.uio_oe  = '1;
            bus.uio_out = owner ? bus.wdata1 : bus.wdata0;
        end
    end

    assign bus.gnt    = gnt;
    assign bus.rdata  = rdata;
    assign bus.rvalid = rvalid;
    assign bus.busy   = (state != IDLE);

endmodule
